// File: rtl/dram_line_buf.sv
// Single-line write-back buffer between a 32-bit CPU port and a 128-bit DRAM line FIFO.
// Optional hit/miss counters are compiled in when LINE_BUF_STATS_EN is defined.
module dram_line_buf #(
   parameter int ADDR_W = 27,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_wstrb,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              fifo_req_valid,
   input  logic              fifo_req_ready,
   output logic              fifo_req_we,
   output logic [ADDR_W-5:0] fifo_req_addr,
   output logic [LINE_W-1:0] fifo_req_wdata,
   input  logic              fifo_rsp_valid,
   output logic              fifo_rsp_ready,
   input  logic [LINE_W-1:0] fifo_rsp_rdata
`ifdef LINE_BUF_STATS_EN
   ,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
`endif
);

   localparam int TAG_W = ADDR_W - 4;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      FILL,
      WAIT,
      RESP,
      FLUSH_WB
   } state_t;

   state_t             state;
   logic [LINE_W-1:0]  line;
   logic [TAG_W-1:0]   tag;
   logic               valid;
   logic               dirty;

   logic               pend_we;
   logic [TAG_W-1:0]   pend_line;
   logic [1:0]         pend_word;
   logic [31:0]        pend_wdata;
   logic [3:0]         pend_wstrb;

   logic               hit;
   logic [TAG_W-1:0]   req_line;
   logic [1:0]         req_word;
   logic               unused_addr_bits;

   function automatic logic [31:0] get_word(input logic [LINE_W-1:0] l,
                                            input logic [1:0]        idx);
      return l[{idx, 5'b00000} +: 32];
   endfunction

   function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] l,
                                                    input logic [1:0]        idx,
                                                    input logic [31:0]       wd,
                                                    input logic [3:0]        strb);
      logic [LINE_W-1:0] r;
      logic [31:0]       w;
      r = l;
      w = get_word(l, idx);
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
      end
      r[{idx, 5'b00000} +: 32] = w;
      return r;
   endfunction

   assign req_line         = cpu_addr[ADDR_W-1:4];
   assign req_word         = cpu_addr[3:2];
   assign unused_addr_bits = ^cpu_addr[1:0];
   assign hit              = valid && (tag == req_line);
   assign cpu_ready        = (state == IDLE) && !rst;

   // NOTE: line, tag and the pending latch carry no reset; valid/dirty qualify them,
   // so leaving the wide datapath unreset keeps reset fan-out off 128+ flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         valid          <= 1'b0;
         dirty          <= 1'b0;
         cpu_rvalid     <= 1'b0;
         cpu_rdata      <= '0;
         flush_done     <= 1'b0;
         fifo_req_valid <= 1'b0;
         fifo_req_we    <= 1'b0;
         fifo_req_addr  <= '0;
         fifo_req_wdata <= '0;
         fifo_rsp_ready <= 1'b0;
      end else begin
         // NOTE: pulses default low here and are raised by the case below;
         // non-blocking assignment makes the later write win within the cycle.
         cpu_rvalid <= 1'b0;
         flush_done <= 1'b0;

         case (state)
            IDLE: begin
               if (cpu_valid) begin
                  pend_we    <= cpu_we;
                  pend_line  <= req_line;
                  pend_word  <= req_word;
                  pend_wdata <= cpu_wdata;
                  pend_wstrb <= cpu_wstrb;
                  if (hit) begin
                     cpu_rvalid <= 1'b1;
                     if (cpu_we) begin
                        line  <= merge_line(line, req_word, cpu_wdata, cpu_wstrb);
                        dirty <= 1'b1;
                     end else begin
                        cpu_rdata <= get_word(line, req_word);
                     end
                  end else if (valid && dirty) begin
                     state          <= WB;
                     fifo_req_valid <= 1'b1;
                     fifo_req_we    <= 1'b1;
                     fifo_req_addr  <= tag;
                     fifo_req_wdata <= line;
                  end else begin
                     state          <= FILL;
                     fifo_req_valid <= 1'b1;
                     fifo_req_we    <= 1'b0;
                     fifo_req_addr  <= req_line;
                  end
               end else if (flush_req) begin
                  if (dirty) begin
                     state          <= FLUSH_WB;
                     fifo_req_valid <= 1'b1;
                     fifo_req_we    <= 1'b1;
                     fifo_req_addr  <= tag;
                     fifo_req_wdata <= line;
                  end else begin
                     flush_done <= 1'b1;
                  end
               end
            end

            WB: begin
               if (fifo_req_ready) begin
                  // The fill request follows straight on; valid stays high across a handshake.
                  dirty         <= 1'b0;
                  state         <= FILL;
                  fifo_req_we   <= 1'b0;
                  fifo_req_addr <= pend_line;
               end
            end

            FILL: begin
               if (fifo_req_ready) begin
                  fifo_req_valid <= 1'b0;
                  fifo_rsp_ready <= 1'b1;
                  state          <= WAIT;
               end
            end

            WAIT: begin
               if (fifo_rsp_valid) begin
                  fifo_rsp_ready <= 1'b0;
                  tag            <= pend_line;
                  valid          <= 1'b1;
                  cpu_rvalid     <= 1'b1;
                  state          <= RESP;
                  if (pend_we) begin
                     line  <= merge_line(fifo_rsp_rdata, pend_word, pend_wdata, pend_wstrb);
                     dirty <= 1'b1;
                  end else begin
                     line      <= fifo_rsp_rdata;
                     dirty     <= 1'b0;
                     cpu_rdata <= get_word(fifo_rsp_rdata, pend_word);
                  end
               end
            end

            RESP: begin
               state <= IDLE;
            end

            FLUSH_WB: begin
               if (fifo_req_ready) begin
                  fifo_req_valid <= 1'b0;
                  dirty          <= 1'b0;
                  flush_done     <= 1'b1;
                  state          <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LINE_BUF_STATS_EN
   // Counts accepted CPU requests only; flushes never pass the cpu handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (cpu_valid && cpu_ready) begin
         if (hit) stat_hits   <= stat_hits + 32'd1;
         else     stat_misses <= stat_misses + 32'd1;
      end
   end
`endif

endmodule

// File: doc/dram_line_buf.md
Name: dram_line_buf

Overview:
- Single-line write-back buffer between a 32-bit CPU load/store port and the 128-bit line-request FIFO in front of the DRAM controller. Sits directly upstream of the DRAM request/response FIFO, in the master position.
- Serves word hits from one buffered 16-byte line in one cycle.
- On a miss, writes back the dirty victim line, then fills the new line.
- Supports an explicit flush of the dirty line.

Parameters:
- ADDR_W, 27, CPU byte-address width; line address is ADDR_W-4 bits.
- LINE_W, 128, line width; fixed to 4 x 32-bit words.

Ports:
- clk  in  1  single clock domain (cpu_clk at top level)
- rst  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU request present
- cpu_ready  out  1  request accepted when cpu_valid && cpu_ready
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  byte address; bits[1:0] ignored
- cpu_wdata  in  32  store data
- cpu_wstrb  in  4  byte enables for stores
- cpu_rvalid  out  1  one-cycle completion pulse (load data or store ack)
- cpu_rdata  out  32  load data, valid with cpu_rvalid
- flush_req  in  1  request write-back of the dirty line
- flush_done  out  1  one-cycle pulse when the flush completes
- fifo_req_valid  out  1  line request to the DRAM FIFO
- fifo_req_ready  in  1  FIFO accepts the request
- fifo_req_we  out  1  1=line write, 0=line read
- fifo_req_addr  out  ADDR_W-4  line address
- fifo_req_wdata  out  LINE_W  write-back line; word0 in bits[31:0]
- fifo_rsp_valid  in  1  read line returned
- fifo_rsp_ready  out  1  buffer accepts the returned line
- fifo_rsp_rdata  in  LINE_W  returned line

Behaviour:
- State registers: line[127:0], tag[ADDR_W-5:0], valid, dirty, plus a pending-request latch (we, addr, wdata, wstrb).
- Reset values:
  - State: IDLE, valid=0, dirty=0.
  - Outputs low: cpu_rvalid, flush_done, fifo_req_valid, fifo_rsp_ready; cpu_rdata=0.
  - Reset mid-operation abandons the operation and loses any dirty data. The DRAM FIFO is reset together with this block.
- cpu_ready = (state==IDLE) && !rst. flush_req is sampled only in IDLE, and only when cpu_valid is low; a CPU request has priority over a flush.
- Hit (valid && tag==cpu_addr[ADDR_W-1:4]):
  - Load: cpu_rvalid asserts the next cycle, with cpu_rdata = line word addr[3:2].
  - Store: bytes are merged per wstrb and dirty is set to 1. cpu_rvalid pulses the next cycle; cpu_rdata is don't-care.
  - After a hit the FSM stays in IDLE, so back-to-back hits sustain one per cycle.
- Miss: the request is latched.
  - If valid && dirty, go to WB. Otherwise go to FILL.
  - WB: fifo_req_valid=1, we=1, addr=tag, wdata=line. On fifo_req_ready, set dirty=0 and go to FILL.
  - FILL: fifo_req_valid=1, we=0, addr=pending line address. On fifo_req_ready, go to WAIT.
  - WAIT: fifo_rsp_ready=1. On fifo_rsp_valid, install the line, set tag, valid=1, dirty=0, then apply the pending op (store merge sets dirty=1). Go to RESP.
  - RESP: cpu_rvalid=1 for one cycle with the correct word, then return to IDLE.
- Clean-miss latency (ready/rsp immediate): accept T, FILL T+1, WAIT T+2, RESP T+3.
- Flush:
  - dirty=1: go to FLUSH_WB (same signalling as WB). On ready, set dirty=0, pulse flush_done, go to IDLE. valid is unchanged.
  - dirty=0: flush_done pulses the next cycle with no FIFO traffic.
- Handshake rules:
  - fifo_req_* stays stable while valid && !ready.
  - fifo_req_valid never drops without a handshake.
  - Only one outstanding read.
  - fifo_rsp_ready is asserted only in WAIT.

Optional Feature:
- Macro LINE_BUF_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Each counts accepted CPU requests by outcome.
  - Both wrap at 2^32 and reset to 0.
  - Flushes are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Cold read:
   - Stimulus: after reset, load 0x0000104; FIFO returns 128'h44444444_33333333_22222222_11111111.
   - Required: one request, we=0, addr=0x000010; then cpu_rvalid with rdata=0x22222222; valid=1, dirty=0.
2. Load hit:
   - Stimulus: load 0x0000108.
   - Required: cpu_rvalid next cycle, rdata=0x33333333, no FIFO activity.
   - Follow-up: 4 back-to-back hits complete in 4 consecutive cycles.
3. Store hit:
   - Stimulus: store 0x000010C, wdata 0xAABBCCDD, wstrb 4'b0011.
   - Required: ack next cycle; a following load of 0x10C returns 0x4444CCDD; dirty=1.
4. Dirty miss:
   - Stimulus: load 0x0000200, with fifo_req_ready held low 3 cycles on each request.
   - Required: WB request we=1, addr=0x10, wdata=128'h4444CCDD_33333333_22222222_11111111, payload stable while stalled; then fill request addr=0x20; correct word returned.
5. Flush:
   - Stimulus: flush_req with dirty=1.
   - Required: one write request, then flush_done pulse, dirty=0.
   - Follow-up: a second flush pulses flush_done the next cycle with no FIFO traffic.
6. Reset in WAIT:
   - Stimulus: assert rst for 1 cycle while in WAIT.
   - Required: IDLE, valid=0, outputs low; a re-issued load of 0x104 misses and issues a fill again.
